// File: rtl/lsu_ctrl_if.sv
// Data-memory request/acknowledge bus between the load/store unit and memory.
interface lsu_ctrl_if;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [3:0]  dm_be;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;

  modport master (
    output dm_req, dm_we, dm_addr, dm_be, dm_wdata,
    input  dm_ack, dm_rdata
  );

  modport slave (
    input  dm_req, dm_we, dm_addr, dm_be, dm_wdata,
    output dm_ack, dm_rdata
  );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store unit: decodes the memory strobes, runs one req/ack access to a
// variable-latency data memory and stalls the core until it completes or times out.
module lsu_ctrl #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Mem,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        fault,
  output logic        bus_err,
  lsu_ctrl_if.master  dm
);

  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LIMIT = CW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dm_req_q, dm_req_d;
  logic          dm_we_q, dm_we_d;
  logic [31:0]   dm_addr_q, dm_addr_d;
  logic [3:0]    dm_be_q, dm_be_d;
  logic [31:0]   dm_wdata_q, dm_wdata_d;
  logic [2:0]    f3_q, f3_d;
  logic [1:0]    lo_q, lo_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          rdata_valid_q, rdata_valid_d;
  logic          bus_err_q, bus_err_d;

  logic          is_load, is_store, f3_ok, aligned;
  logic          stall_c, fault_c;
  logic [3:0]    be_new;
  logic [31:0]   wdata_new;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic [31:0]   load_ext;

  // MemRead wins over MemWrite; MemWrite alone without Mem is a JALR artefact.
  always_comb begin
    is_load  = Mem & MemRead;
    is_store = Mem & MemWrite & ~MemRead;
    if (is_load)
      f3_ok = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
              (funct3 == 3'b100) || (funct3 == 3'b101);
    else
      f3_ok = ~funct3[2] && (funct3[1:0] != 2'b11);
    case (funct3[1:0])
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~addr[0];
      default: aligned = (addr[1:0] == 2'b00);
    endcase

    be_new    = '1;
    wdata_new = wdata;
    if (is_store) begin
      case (funct3[1:0])
        2'b00: begin
          be_new    = 4'b0001 << addr[1:0];
          wdata_new = {4{wdata[7:0]}};
        end
        2'b01: begin
          be_new    = addr[1] ? 4'b1100 : 4'b0011;
          wdata_new = {2{wdata[15:0]}};
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    case (lo_q)
      2'b00:   byte_sel = dm.dm_rdata[7:0];
      2'b01:   byte_sel = dm.dm_rdata[15:8];
      2'b10:   byte_sel = dm.dm_rdata[23:16];
      default: byte_sel = dm.dm_rdata[31:24];
    endcase
    half_sel = lo_q[1] ? dm.dm_rdata[31:16] : dm.dm_rdata[15:0];
    case (f3_q)
      3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_ext = {24'h0, byte_sel};
      3'b101:  load_ext = {16'h0, half_sel};
      default: load_ext = dm.dm_rdata;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    dm_req_d      = dm_req_q;
    dm_we_d       = dm_we_q;
    dm_addr_d     = dm_addr_q;
    dm_be_d       = dm_be_q;
    dm_wdata_d    = dm_wdata_q;
    f3_d          = f3_q;
    lo_d          = lo_q;
    rdata_d       = '0;
    rdata_valid_d = 1'b0;
    bus_err_d     = 1'b0;
    stall_c       = 1'b0;
    fault_c       = 1'b0;

    case (state_q)
      IDLE: begin
        if (is_load || is_store) begin
          if (f3_ok && aligned) begin
            stall_c    = 1'b1;
            dm_req_d   = 1'b1;
            dm_we_d    = is_store;
            dm_addr_d  = {addr[31:2], 2'b00};
            dm_be_d    = be_new;
            dm_wdata_d = wdata_new;
            f3_d       = funct3;
            lo_d       = addr[1:0];
            cnt_d      = '0;
            state_d    = BUSY;
          end else begin
            fault_c = 1'b1;
          end
        end
      end
      BUSY: begin
        stall_c = 1'b1;
        if (dm.dm_ack) begin
          dm_req_d = 1'b0;
          dm_we_d  = 1'b0;
          state_d  = DONE;
          if (!dm_we_q) begin
            rdata_d       = load_ext;
            rdata_valid_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_d == TO_LIMIT) begin
            dm_req_d  = 1'b0;
            dm_we_d   = 1'b0;
            bus_err_d = 1'b1;
            state_d   = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      dm_req_q      <= 1'b0;
      dm_we_q       <= 1'b0;
      dm_addr_q     <= '0;
      dm_be_q       <= '0;
      dm_wdata_q    <= '0;
      f3_q          <= '0;
      lo_q          <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      bus_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      dm_req_q      <= dm_req_d;
      dm_we_q       <= dm_we_d;
      dm_addr_q     <= dm_addr_d;
      dm_be_q       <= dm_be_d;
      dm_wdata_q    <= dm_wdata_d;
      f3_q          <= f3_d;
      lo_q          <= lo_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      bus_err_q     <= bus_err_d;
    end
  end

  // The decode-driven pulses are gated so reset silences them immediately.
  assign stall       = stall_c & ~reset;
  assign fault       = fault_c & ~reset;
  assign rdata       = rdata_q;
  assign rdata_valid = rdata_valid_q;
  assign bus_err     = bus_err_q;
  assign dm.dm_req   = dm_req_q;
  assign dm.dm_we    = dm_we_q;
  assign dm.dm_addr  = dm_addr_q;
  assign dm.dm_be    = dm_be_q;
  assign dm.dm_wdata = dm_wdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: directed test-plan accesses followed by random accesses,
// each checked against an arithmetic reference model of the load/store rules.
module tb_lsu_ctrl;
  localparam int unsigned TO = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic        Mem, MemRead, MemWrite;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        stall, rdata_valid, fault, bus_err;
  logic [31:0] rdata;

  int total = 0;
  int bad   = 0;

  lsu_ctrl_if dmif ();

  lsu_ctrl #(.TIMEOUT(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .Mem         (Mem),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .funct3      (funct3),
    .addr        (addr),
    .wdata       (wdata),
    .stall       (stall),
    .rdata       (rdata),
    .rdata_valid (rdata_valid),
    .fault       (fault),
    .bus_err     (bus_err),
    .dm          (dmif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: size from funct3[1:0], lane offset from addr%4, values by shift/mask.
  function automatic void model(input bit mem, input bit rd, input bit wr,
                                input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, input logic [31:0] rdat,
                                output bit go, output bit flt, output bit ld,
                                output logic [3:0] be, output logic [31:0] wv,
                                output logic [31:0] rv);
    int unsigned sz, off;
    longint unsigned mask, v, rep;
    bit active, legal;
    active = mem && (rd || wr);
    ld     = rd;
    sz     = 1 << f3[1:0];
    off    = a % 4;
    legal  = rd ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 inside {3'd0, 3'd1, 3'd2});
    legal  = legal && (off % sz == 0);
    go     = active && legal;
    flt    = active && !legal;
    mask   = (sz <= 4) ? ((64'd1 << (8 * sz)) - 1) : 64'd0;
    be     = ld ? 4'hF : 4'(((1 << sz) - 1) << off);
    rep    = 0;
    if (sz <= 4)
      for (int unsigned k = 0; k < 4 / sz; k++) rep += 64'd1 << (8 * sz * k);
    wv = 32'((longint'(wd) & mask) * rep);
    v  = (longint'(rdat) >> (8 * off)) & mask;
    if (!f3[2] && sz < 4 && v >= (mask + 1) / 2) v = v - (mask + 1);
    rv = 32'(v);
  endfunction

  task automatic drop();
    Mem = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
  endtask

  // Called at posedge+1; returns at posedge+1. lat<0 means the memory never acks.
  task automatic access(input bit mem, input bit rd, input bit wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input int lat,
                        input logic [31:0] rdat);
    bit go, flt, ld, ack_now, tout;
    logic [3:0] ebe;
    logic [31:0] ewd, erd;
    int n, nstall;
    model(mem, rd, wr, f3, a, wd, rdat, go, flt, ld, ebe, ewd, erd);
    Mem = mem; MemRead = rd; MemWrite = wr; funct3 = f3; addr = a; wdata = wd;
    dmif.dm_ack = 1'b0;
    #1;
    chk("fault", fault, flt);
    chk("stall_detect", stall, go);
    chk("req_detect", dmif.dm_req, 0);
    nstall = int'(stall);
    @(posedge clk); #1;
    if (!go) begin
      chk("no_req", dmif.dm_req, 0);
      chk("no_stall", stall, 0);
      drop();
      #1;
      chk("fault_clear", fault, 0);
      @(posedge clk); #1;
      return;
    end
    n = 0; tout = 1'b0;
    while (1) begin
      ack_now = (lat >= 0) && (n == lat);
      dmif.dm_ack   = ack_now;
      dmif.dm_rdata = ack_now ? rdat : $urandom;
      #1;
      chk("busy_req", dmif.dm_req, 1);
      chk("busy_addr", dmif.dm_addr, {a[31:2], 2'b00});
      chk("busy_be", dmif.dm_be, ebe);
      chk("busy_we", dmif.dm_we, !ld);
      if (!ld) chk("busy_wdata", dmif.dm_wdata, ewd);
      nstall += int'(stall);
      @(posedge clk); #1;
      dmif.dm_ack = 1'b0;
      n++;
      if (ack_now) break;
      if (n == int'(TO)) begin tout = 1'b1; break; end
    end
    #1;
    chk("done_stall", stall, 0);
    chk("done_req", dmif.dm_req, 0);
    chk("done_valid", rdata_valid, ld && !tout);
    chk("done_buserr", bus_err, tout);
    if (ld && !tout) chk("done_rdata", rdata, erd);
    if (tout) chk("err_rdata", rdata, 0);
    chk("stall_cycles", nstall, tout ? TO + 1 : lat + 2);
    @(posedge clk); #1;
    drop();
    #1;
    chk("after_valid", rdata_valid, 0);
    chk("after_buserr", bus_err, 0);
    chk("after_req", dmif.dm_req, 0);
    chk("after_stall", stall, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [2:0] f3;
    logic [31:0] a;
    int lat;
    reset = 1'b1; drop(); funct3 = 3'b0; addr = '0; wdata = '0;
    dmif.dm_ack = 1'b0; dmif.dm_rdata = '0;
    #3;
    chk("rst_stall", stall, 0);
    chk("rst_valid", rdata_valid, 0);
    chk("rst_fault", fault, 0);
    chk("rst_buserr", bus_err, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_req", dmif.dm_req, 0);
    chk("rst_we", dmif.dm_we, 0);
    chk("rst_addr", dmif.dm_addr, 0);
    chk("rst_be", dmif.dm_be, 0);
    chk("rst_wdata", dmif.dm_wdata, 0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    access(1, 1, 0, 3'b010, 32'h100, 32'h0, 2, 32'hDEADBEEF);       // LW
    access(1, 1, 0, 3'b000, 32'h103, 32'h0, 0, 32'h80FF1234);       // LB
    access(1, 1, 0, 3'b100, 32'h103, 32'h0, 1, 32'h80FF1234);       // LBU
    access(1, 1, 0, 3'b001, 32'h102, 32'h0, 0, 32'h80FF1234);       // LH
    access(1, 0, 1, 3'b000, 32'h2, 32'h000000AB, 0, 32'h0);         // SB
    access(1, 0, 1, 3'b001, 32'h2, 32'h1234CDEF, 3, 32'h0);         // SH
    access(1, 0, 1, 3'b010, 32'h40, 32'hCAFEF00D, 1, 32'h0);        // SW
    access(1, 1, 0, 3'b010, 32'h101, 32'h0, 0, 32'h0);              // misaligned LW
    access(1, 1, 0, 3'b011, 32'h100, 32'h0, 0, 32'h0);              // illegal funct3
    access(0, 0, 1, 3'b000, 32'h100, 32'h55, 0, 32'h0);             // JALR strobe
    access(1, 1, 1, 3'b101, 32'h106, 32'h77, 0, 32'h8001F00F);      // both strobes: load
    access(1, 1, 0, 3'b010, 32'h300, 32'h0, -1, 32'h0);             // timeout

    // Reset mid-wait, then a stray ack after release.
    Mem = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; funct3 = 3'b010; addr = 32'h200;
    #1;
    chk("rb_detect", stall, 1);
    @(posedge clk); #1;
    chk("rb_req", dmif.dm_req, 1);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("rb_req_drop", dmif.dm_req, 0);
    chk("rb_stall_drop", stall, 0);
    @(posedge clk); #1;
    reset = 1'b0; drop();
    dmif.dm_ack = 1'b1; dmif.dm_rdata = 32'h12345678;
    @(posedge clk); #1;
    dmif.dm_ack = 1'b0;
    #1;
    chk("rb_late_valid", rdata_valid, 0);
    chk("rb_late_req", dmif.dm_req, 0);
    chk("rb_late_buserr", bus_err, 0);
    @(posedge clk); #1;

    for (int i = 0; i < 60; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ~(32'(1 << f3[1:0]) - 32'd1);
      lat = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 4));
      access($urandom_range(0, 7) != 0, 1'($urandom), 1'($urandom), f3, a, $urandom,
             lat, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store unit between the ALU and the data memory in the single-cycle RISC-V datapath. It consumes the `Mem`, `MemRead` and `MemWrite` strobes produced by the main decoder, together with `funct3`, the ALU address and rs2. It runs a req/ack transaction to a variable-latency data memory and returns a sign- or zero-extended load result. It stalls the core (PC and register-file write) until the access completes, faults, or times out.

## Interface
Parameters:
- `TIMEOUT`, 15: number of BUSY cycles without `dm_ack` before the access is aborted with `bus_err`.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `Mem`  in  1  decoder strobe: the instruction is a load or a store.
- `MemRead`  in  1  load strobe.
- `MemWrite`  in  1  store strobe.
- `funct3`  in  3  access size and signedness.
- `addr`  in  32  byte address (ALU result).
- `wdata`  in  32  store data (rs2).
- `stall`  out  1  holds the PC and suppresses register write while high.
- `rdata`  out  32  extended load result; valid only while `rdata_valid` is high.
- `rdata_valid`  out  1  one-cycle pulse on load completion.
- `fault`  out  1  one-cycle pulse on a misaligned access or illegal `funct3`.
- `bus_err`  out  1  one-cycle pulse on timeout.
- `dm_req`  out  1  memory request; registered; held until ack.
- `dm_we`  out  1  memory write enable.
- `dm_addr`  out  32  word address: `{addr[31:2],2'b00}`.
- `dm_be`  out  4  byte enables.
- `dm_wdata`  out  32  lane-replicated store data.
- `dm_ack`  in  1  memory completion.
- `dm_rdata`  in  32  read data; sampled only in the ack cycle.

## Operation
- An access starts only when `Mem`=1 and (`MemRead` or `MemWrite`). `MemWrite` with `Mem`=0 (the decoder raises it for JALR) is ignored. `MemRead` takes priority if both are high.
- Legal load `funct3` values: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- Legal store `funct3` values: 000 SB, 001 SH, 010 SW.
- Alignment rules: halfword requires `addr[0]`=0; word requires `addr[1:0]`=0.
- FSM states: IDLE, BUSY, DONE.
- IDLE, access with illegal `funct3` or misaligned address: `fault`=1 (combinational), `stall`=0, no request issued; stay in IDLE.
- IDLE, legal access: `stall`=1 combinationally. Latch `we`, `be`, `dm_addr`, `dm_wdata`, `funct3` and `addr[1:0]`, clear the timeout counter, go to BUSY.
- BUSY: `dm_req`=1, `stall`=1.
  - On `dm_ack`: capture and extend `dm_rdata` (loads), go to DONE.
  - Otherwise increment the counter. When it reaches `TIMEOUT`, go to DONE with an error flag set.
- DONE: `stall`=0.
  - Load: `rdata_valid`=1.
  - Error: `bus_err`=1, `rdata_valid`=0, `rdata`=0.
  - Always return to IDLE. Inputs still present in DONE (same instruction) must not restart an access.
- Byte enables:
  - SB: `be`=1<<`addr[1:0]`, byte replicated ×4.
  - SH: `be`=0011 when `addr[1]`=0, 1100 when `addr[1]`=1; halfword replicated ×2.
  - SW: `be`=1111.
  - Loads: `be`=1111, `dm_we`=0.
- Load extraction:
  - Select the byte or half lane by `addr[1:0]`.
  - LB/LH sign-extend bit 7/15; LBU/LHU zero-extend.
  - LW passes the word through.
- `dm_ack` outside BUSY is ignored.

## Timing
- Reset (asynchronous, immediate):
  - State goes to IDLE and the counter clears.
  - `dm_req`, `dm_we`, `stall`, `rdata_valid`, `fault` and `bus_err` go to 0; `rdata`, `dm_addr`, `dm_be` and `dm_wdata` go to 0.
  - Reset mid-BUSY drops `dm_req` at once. A late `dm_ack` after reset release is ignored.
- Zero-wait memory (ack in the first BUSY cycle):
  - Cycle 0: IDLE, `stall`=1.
  - Cycle 1: BUSY, `dm_req`=1, ack.
  - Cycle 2: DONE, `rdata_valid`=1, `stall`=0.
  - Total: 2 stall cycles. Each extra wait cycle adds 1.
- Timeout: `bus_err` appears `TIMEOUT`+1 cycles after the IDLE detect cycle.
- `dm_addr`, `dm_be`, `dm_we` and `dm_wdata` are stable for the whole of `dm_req`. The core holds all inputs stable while `stall`=1.
- `fault` pulses in the same cycle as the offending instruction and never asserts `stall`.

## Test plan
- LW: `addr`=0x100, ack after 2 wait cycles, `dm_rdata`=0xDEADBEEF. Expect `dm_be`=1111, `dm_we`=0, 4 stall cycles, `rdata`=0xDEADBEEF with `rdata_valid` for exactly 1 cycle.
- LB / LBU: `addr`=0x103, `dm_rdata`=0x80FF1234. Expect LB `rdata`=0xFFFFFF80 and LBU `rdata`=0x00000080. LH at 0x102 gives 0xFFFF80FF.
- SB: `addr`=0x2, `wdata`=0x000000AB. Expect `dm_be`=0100, `dm_wdata`=0xABABABAB, `dm_we`=1. SH at 0x2 gives `dm_be`=1100.
- Misaligned and ignored accesses: LW at 0x101 gives a `fault` pulse, no `dm_req`, `stall`=0. `Mem`=0 with `MemWrite`=1 (JALR) produces no activity.
- Timeout: load with `dm_ack` tied to 0 and `TIMEOUT`=15. Expect `bus_err` pulse 16 cycles after the start, `rdata_valid`=0, FSM back in IDLE.
- Reset in BUSY: assert `reset` mid-wait. Expect `dm_req` and `stall` to drop asynchronously. An ack arriving after release causes no `rdata_valid`.
